// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the operate-instruction sequencer.
// Opcodes, ALU select codes and the controller state encoding live here.
`timescale 1ns/1ps
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_sel_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_t;

endpackage

// File: rtl/alu_sequencer_op_decode.sv
// Combinational opcode decoder: ALU select, legality, immediate mode and
// the sign-extended imm5 field of an operate instruction.
`timescale 1ns/1ps
module op_decode
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] instr,
    output logic [1:0]       alu_select,
    output logic             legal,
    output logic             use_imm,
    output logic [WIDTH-1:0] imm_sext
);

    // Register fields are consumed by the sequencer, not by this decoder.
    logic w_unused_fields;
    assign w_unused_fields = ^instr[11:6];

    assign imm_sext = {{(WIDTH-5){instr[4]}}, instr[4:0]};

    always_comb begin
        alu_select = ALU_PASS;
        legal      = 1'b0;
        use_imm    = 1'b0;
        case (instr[15:12])
            OP_ADD: begin
                alu_select = ALU_ADD;
                legal      = 1'b1;
                use_imm    = instr[5];
            end
            OP_AND: begin
                alu_select = ALU_AND;
                legal      = 1'b1;
                use_imm    = instr[5];
            end
            OP_NOT: begin
                // NOT ignores ir[5:0]; operand B is don't-care to the ALU.
                alu_select = ALU_NOT;
                legal      = 1'b1;
                use_imm    = 1'b0;
            end
            default: begin
                alu_select = ALU_PASS;
                legal      = 1'b0;
                use_imm    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller running one ADD/AND/NOT at a time through the
// external ALU and register file, with writeback and NZP condition codes.
`timescale 1ns/1ps
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] instr,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [RA_W-1:0]  rf_raddr1,
    output logic [RA_W-1:0]  rf_raddr2,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [WIDTH-1:0] alu_d0,
    output logic [WIDTH-1:0] alu_d1,
    output logic [1:0]       alu_select,
    input  logic [WIDTH-1:0] alu_dout,
    output logic             cc_n,
    output logic             cc_z,
    output logic             cc_p,
    output logic [1:0]       dbg_state
);

    // Handshake: an instruction is taken on a clock edge where start=1 and
    // ready=1; ready stays low until the cycle after writeback (or error).

    state_t           r_state;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_alu_sel;
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic             r_rf_we;
    logic             r_cc_n;
    logic             r_cc_z;
    logic             r_cc_p;

    logic [1:0]       w_alu_sel;
    logic             w_legal;
    logic             w_use_imm;
    logic [WIDTH-1:0] w_imm;

    op_decode #(.WIDTH(WIDTH)) u_op_decode (
        .instr      (r_ir),
        .alu_select (w_alu_sel),
        .legal      (w_legal),
        .use_imm    (w_use_imm),
        .imm_sext   (w_imm)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_result  <= '0;
            r_alu_sel <= ALU_PASS;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rf_we   <= 1'b0;
            r_cc_n    <= 1'b0;
            r_cc_z    <= 1'b1;
            r_cc_p    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rf_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ir    <= instr;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        // Operands are captured here, so DR may alias SR1/SR2.
                        r_op_a    <= rf_rdata1;
                        r_op_b    <= w_use_imm ? w_imm : rf_rdata2;
                        r_alu_sel <= w_alu_sel;
                        r_state   <= S_EXEC;
                    end else begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_dout;
                    r_rf_we  <= 1'b1;
                    r_done   <= 1'b1;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_cc_n  <= r_result[WIDTH-1];
                    r_cc_z  <= (r_result == '0);
                    r_cc_p  <= !r_result[WIDTH-1] && (r_result != '0);
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign done       = r_done;
    assign err        = r_err;
    assign rf_raddr1  = r_ir[8:6];
    assign rf_raddr2  = r_ir[2:0];
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_ir[11:9];
    assign rf_wdata   = r_result;
    assign alu_d0     = r_op_a;
    assign alu_d1     = r_op_b;
    assign alu_select = r_alu_sel;
    assign cc_n       = r_cc_n;
    assign cc_z       = r_cc_z;
    assign cc_p       = r_cc_p;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU.
// Table of single instructions plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  instr;
    logic          ready, done, err;
    logic [2:0]    rf_raddr1, rf_raddr2, rf_waddr;
    logic [W-1:0]  rf_rdata1, rf_rdata2, rf_wdata;
    logic          rf_we;
    logic [W-1:0]  alu_d0, alu_d1, alu_dout;
    logic [1:0]    alu_select;
    logic          cc_n, cc_z, cc_p;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(16), .RA_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr      (instr),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_d0     (alu_d0),
        .alu_d1     (alu_d1),
        .alu_select (alu_select),
        .alu_dout   (alu_dout),
        .cc_n       (cc_n),
        .cc_z       (cc_z),
        .cc_p       (cc_p),
        .dbg_state  (dbg_state)
    );

    // Behavioural register file and ALU
    logic [W-1:0] rf [8];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always_comb begin
        case (alu_select)
            2'b00:   alu_dout = alu_d0 + alu_d1;
            2'b01:   alu_dout = alu_d0 & alu_d1;
            2'b10:   alu_dout = ~alu_d0;
            default: alu_dout = alu_d0;
        endcase
    end

    int we_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] = rf_wdata;
            we_cnt = we_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 20) begin
            tick();
            k++;
        end
        if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W-1:0] instr;
        logic [2:0]   dr;
        logic [W-1:0] d1;
        logic [W-1:0] wdata;
        logic [2:0]   cc;   // {n,z,p}
    } vec_t;

    vec_t vecs[9];
    logic [W-1:0] bseq[9];
    int we_base, done_base;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;

        vecs[0] = '{16'h0005, 16'h0003, 16'h1042, 3'd0, 16'h0003, 16'h0008, 3'b001};
        vecs[1] = '{16'h0005, 16'h0003, 16'h167B, 3'd3, 16'hFFFB, 16'h0000, 3'b010};
        vecs[2] = '{16'h0005, 16'h0003, 16'h5860, 3'd4, 16'h0000, 16'h0000, 3'b010};
        vecs[3] = '{16'h0005, 16'h0003, 16'h9A7F, 3'd5, 16'h0000, 16'hFFFA, 3'b100};
        vecs[4] = '{16'h7FFF, 16'h0001, 16'h1042, 3'd0, 16'h0001, 16'h8000, 3'b100};
        vecs[5] = '{16'hFFFF, 16'h0002, 16'h1C42, 3'd6, 16'h0002, 16'h0001, 3'b001};
        vecs[6] = '{16'h0010, 16'h0020, 16'h1242, 3'd1, 16'h0020, 16'h0030, 3'b001};
        vecs[7] = '{16'hF0F0, 16'h3C3C, 16'h5442, 3'd2, 16'h3C3C, 16'h3030, 3'b001};
        vecs[8] = '{16'hFFF0, 16'h0000, 16'h166F, 3'd3, 16'h000F, 16'hFFFF, 3'b100};

        bseq[0] = 16'h1642; bseq[1] = 16'h1842; bseq[2] = 16'h1842;
        bseq[3] = 16'h1842; bseq[4] = 16'h1A42; bseq[5] = 16'h1842;
        bseq[6] = 16'h1842; bseq[7] = 16'h1842; bseq[8] = 16'h5C42;

        // Reset, with start held high to show reset wins
        reset = 1'b1;
        start = 1'b1;
        instr = 16'h1042;
        repeat (3) tick();
        check("rst_state_with_start", {30'd0, dbg_state}, 32'd0);
        start = 1'b0;
        instr = '0;
        reset = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_cc", {29'd0, cc_n, cc_z, cc_p}, 32'b010);
        check("rst_sel", {30'd0, alu_select}, 32'd3);
        check("rst_d0", {16'd0, alu_d0}, 32'd0);
        check("rst_d1", {16'd0, alu_d1}, 32'd0);
        check("rst_wdata", {16'd0, rf_wdata}, 32'd0);

        // Single-instruction table
        for (int i = 0; i < 9; i++) begin
            rf[1] = vecs[i].r1;
            rf[2] = vecs[i].r2;
            wait_ready();
            start = 1'b1;
            instr = vecs[i].instr;
            tick();
            start = 1'b0;
            instr = 16'hFFFF;
            check($sformatf("v%0d_ready_c1", i), {31'd0, ready}, 32'd0);
            tick();
            check($sformatf("v%0d_d1_c2", i), {16'd0, alu_d1}, {16'd0, vecs[i].d1});
            check($sformatf("v%0d_we_c2", i), {31'd0, rf_we}, 32'd0);
            tick();
            check($sformatf("v%0d_we_c3", i), {31'd0, rf_we}, 32'd1);
            check($sformatf("v%0d_done_c3", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_waddr", i), {29'd0, rf_waddr}, {29'd0, vecs[i].dr});
            check($sformatf("v%0d_wdata", i), {16'd0, rf_wdata}, {16'd0, vecs[i].wdata});
            tick();
            check($sformatf("v%0d_cc_c4", i), {29'd0, cc_n, cc_z, cc_p}, {29'd0, vecs[i].cc});
            check($sformatf("v%0d_ready_c4", i), {31'd0, ready}, 32'd1);
            check($sformatf("v%0d_done_c4", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_rf", i), {16'd0, rf[vecs[i].dr]}, {16'd0, vecs[i].wdata});
        end

        // Illegal opcode: err at cycle 2, no write, CCs stay at N
        we_base = we_cnt;
        wait_ready();
        start = 1'b1;
        instr = 16'hF025;
        tick();
        start = 1'b0;
        check("ill_err_c1", {31'd0, err}, 32'd0);
        check("ill_ready_c1", {31'd0, ready}, 32'd0);
        tick();
        check("ill_err_c2", {31'd0, err}, 32'd1);
        check("ill_ready_c2", {31'd0, ready}, 32'd1);
        check("ill_cc_c2", {29'd0, cc_n, cc_z, cc_p}, 32'b100);
        check("ill_state_c2", {30'd0, dbg_state}, 32'd0);
        tick();
        check("ill_err_c3", {31'd0, err}, 32'd0);
        check("ill_no_write", we_cnt - we_base, 32'd0);

        // Back-to-back with start held: only cycles 0, 4, 8 are sampled
        rf[1] = 16'h0005;
        rf[2] = 16'h0003;
        rf[3] = '0;
        rf[4] = 16'h0BAD;
        rf[5] = '0;
        rf[6] = '0;
        wait_ready();
        done_base = done_cnt;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) check("b2b_ready_c4", {31'd0, ready}, 32'd1);
            instr = bseq[k];
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
        check("b2b_done_count", done_cnt - done_base, 32'd3);
        check("b2b_r3", {16'd0, rf[3]}, 32'h0008);
        check("b2b_r5", {16'd0, rf[5]}, 32'h0008);
        check("b2b_r6", {16'd0, rf[6]}, 32'h0001);
        check("b2b_r4_untouched", {16'd0, rf[4]}, 32'h0BAD);
        check("b2b_cc", {29'd0, cc_n, cc_z, cc_p}, 32'b001);

        // Reset during EXEC abandons the instruction
        rf[0] = 16'h0BAD;
        rf[1] = 16'h0005;
        rf[2] = 16'h0003;
        wait_ready();
        we_base = we_cnt;
        done_base = done_cnt;
        start = 1'b1;
        instr = 16'h1042;
        tick();
        start = 1'b0;
        tick();
        check("rmid_state_exec", {30'd0, dbg_state}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_state", {30'd0, dbg_state}, 32'd0);
        check("rmid_ready", {31'd0, ready}, 32'd1);
        check("rmid_we", {31'd0, rf_we}, 32'd0);
        check("rmid_done", {31'd0, done}, 32'd0);
        check("rmid_cc", {29'd0, cc_n, cc_z, cc_p}, 32'b010);
        check("rmid_sel", {30'd0, alu_select}, 32'd3);
        repeat (3) tick();
        check("rmid_r0_untouched", {16'd0, rf[0]}, 32'h0BAD);
        check("rmid_no_we", we_cnt - we_base, 32'd0);
        check("rmid_no_done", done_cnt - done_base, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
